// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp codes and a small helper for the intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G    = 3'd0,
        MAIN_Y    = 3'd1,
        ALL_RED_A = 3'd2,
        SIDE_G    = 3'd3,
        SIDE_Y    = 3'd4,
        ALL_RED_B = 3'd5,
        FLASH     = 3'd6
    } phase_e;

    localparam logic [2:0] RGY_RED = 3'b100;
    localparam logic [2:0] RGY_YEL = 3'b010;
    localparam logic [2:0] RGY_GRN = 3'b001;
    localparam logic [2:0] RGY_OFF = 3'b000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_timer.sv
// Phase down-counter: loads duration-1, counts down on enabled cycles, parks at zero.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int            TW      = 4,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_an,
    input  logic          en,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] cnt,
    output logic          zero
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller with all-red clearance, latched pedestrian call,
// maintenance flash mode and a freeze enable.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int MAIN_MIN_GREEN = 20,
    parameter int SIDE_GREEN     = 10,
    parameter int YELLOW         = 3,
    parameter int ALL_RED        = 2,
    parameter int FLASH_HALF     = 4
) (
    input  logic       clk,
    input  logic       rst_an,
    input  logic       en,
    input  logic       flash_mode,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam int MAXD = max_int(max_int(max_int(MAIN_MIN_GREEN, SIDE_GREEN),
                                          max_int(YELLOW, ALL_RED)), FLASH_HALF);
    localparam int TW   = $clog2(MAXD) + 1;

    localparam logic [TW-1:0] LD_MG = TW'(MAIN_MIN_GREEN - 1);
    localparam logic [TW-1:0] LD_SG = TW'(SIDE_GREEN - 1);
    localparam logic [TW-1:0] LD_Y  = TW'(YELLOW - 1);
    localparam logic [TW-1:0] LD_AR = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] LD_FH = TW'(FLASH_HALF - 1);

    phase_e        state_q, state_d;
    logic          flash_ph_q, flash_ph_d;
    logic          ped_pend_q, served_q, ped_ack_q;
    logic          load, timer_zero, demand, enter_side;
    logic [TW-1:0] load_val, timer_cnt;

    phase_timer #(.TW(TW), .RST_VAL(LD_AR)) u_timer (
        .clk      (clk),
        .rst_an   (rst_an),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .cnt      (timer_cnt),
        .zero     (timer_zero)
    );

    // A request arriving on the expiry cycle already counts as demand.
    always_comb begin
        state_d    = state_q;
        flash_ph_d = flash_ph_q;
        load       = 1'b0;
        load_val   = '0;
        demand     = side_sensor | ped_pend_q | ped_req;
        if (en) begin
            unique case (state_q)
                MAIN_G: if (timer_zero && demand) begin
                    state_d = MAIN_Y;    load = 1'b1; load_val = LD_Y;
                end
                MAIN_Y: if (timer_zero) begin
                    state_d = ALL_RED_A; load = 1'b1; load_val = LD_AR;
                end
                ALL_RED_A: if (timer_zero) begin
                    load = 1'b1;
                    if (flash_mode) begin
                        state_d = FLASH;  load_val = LD_FH; flash_ph_d = 1'b0;
                    end else begin
                        state_d = SIDE_G; load_val = LD_SG;
                    end
                end
                SIDE_G: if (timer_zero) begin
                    state_d = SIDE_Y;    load = 1'b1; load_val = LD_Y;
                end
                SIDE_Y: if (timer_zero) begin
                    state_d = ALL_RED_B; load = 1'b1; load_val = LD_AR;
                end
                ALL_RED_B: if (timer_zero) begin
                    load = 1'b1;
                    if (flash_mode) begin
                        state_d = FLASH;  load_val = LD_FH; flash_ph_d = 1'b0;
                    end else begin
                        state_d = MAIN_G; load_val = LD_MG;
                    end
                end
                FLASH: if (!flash_mode) begin
                    state_d = ALL_RED_B; load = 1'b1; load_val = LD_AR;
                end else if (timer_cnt == '0) begin
                    flash_ph_d = ~flash_ph_q; load = 1'b1; load_val = LD_FH;
                end
                default: begin
                    state_d = ALL_RED_B; load = 1'b1; load_val = LD_AR;
                end
            endcase
        end
    end

    assign enter_side = (state_d == SIDE_G) && (state_q != SIDE_G);

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= ALL_RED_B;
            flash_ph_q <= 1'b0;
            ped_pend_q <= 1'b0;
            served_q   <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flash_ph_q <= flash_ph_d;
            ped_pend_q <= ped_req | (ped_pend_q & ~enter_side);
            ped_ack_q  <= enter_side & ped_pend_q;
            if (enter_side) begin
                served_q <= ped_pend_q;
            end
        end
    end

    always_comb begin
        main_rgy = RGY_RED;
        side_rgy = RGY_RED;
        walk     = 1'b0;
        unique case (state_q)
            MAIN_G:  main_rgy = RGY_GRN;
            MAIN_Y:  main_rgy = RGY_YEL;
            SIDE_G: begin
                side_rgy = RGY_GRN;
                walk     = served_q;
            end
            SIDE_Y:  side_rgy = RGY_YEL;
            FLASH: begin
                main_rgy = flash_ph_q ? RGY_OFF : RGY_YEL;
                side_rgy = flash_ph_q ? RGY_OFF : RGY_RED;
            end
            default: ;
        endcase
    end

    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios plus randomized traffic
// checked against a phase/age reference model.
module tb_traffic_intersection_ctrl;
    import traffic_pkg::*;

    localparam int MAIN_MIN_GREEN = 20;
    localparam int SIDE_GREEN     = 10;
    localparam int YELLOW         = 3;
    localparam int ALL_RED        = 2;
    localparam int FLASH_HALF     = 4;

    logic       clk = 1'b0;
    logic       rst_an = 1'b0;
    logic       en = 1'b1;
    logic       flash_mode = 1'b0;
    logic       side_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_rgy, side_rgy, phase;
    logic       walk, ped_ack;
    logic [10:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: current phase, cycles spent in it (1-based), pedestrian flags
    phase_e m_ph;
    int     m_age;
    bit     m_pend, m_served, m_ack;

    traffic_intersection_ctrl #(
        .MAIN_MIN_GREEN (MAIN_MIN_GREEN),
        .SIDE_GREEN     (SIDE_GREEN),
        .YELLOW         (YELLOW),
        .ALL_RED        (ALL_RED),
        .FLASH_HALF     (FLASH_HALF)
    ) dut (
        .clk         (clk),
        .rst_an      (rst_an),
        .en          (en),
        .flash_mode  (flash_mode),
        .side_sensor (side_sensor),
        .ped_req     (ped_req),
        .main_rgy    (main_rgy),
        .side_rgy    (side_rgy),
        .walk        (walk),
        .ped_ack     (ped_ack),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    assign dut_vec = {main_rgy, side_rgy, walk, ped_ack, phase};

    function automatic logic [10:0] model_vec();
        logic [2:0] mr, sr, p;
        logic       w;
        bit         lit;
        mr  = 3'b100;
        sr  = 3'b100;
        w   = 1'b0;
        p   = m_ph;
        lit = (((m_age - 1) / FLASH_HALF) % 2) == 0;
        case (m_ph)
            MAIN_G: mr = 3'b001;
            MAIN_Y: mr = 3'b010;
            SIDE_G: begin sr = 3'b001; w = m_served; end
            SIDE_Y: sr = 3'b010;
            FLASH: begin
                mr = lit ? 3'b010 : 3'b000;
                sr = lit ? 3'b100 : 3'b000;
            end
            default: ;
        endcase
        return {mr, sr, w, logic'(m_ack), p};
    endfunction

    task automatic model_step();
        phase_e nx;
        bit     es;
        nx = m_ph;
        if (!en) begin
            m_pend = m_pend | ped_req;
            m_ack  = 1'b0;
            return;
        end
        case (m_ph)
            MAIN_G:    if (m_age >= MAIN_MIN_GREEN && (side_sensor || m_pend || ped_req)) nx = MAIN_Y;
            MAIN_Y:    if (m_age >= YELLOW) nx = ALL_RED_A;
            ALL_RED_A: if (m_age >= ALL_RED) begin
                if (flash_mode) nx = FLASH; else nx = SIDE_G;
            end
            SIDE_G:    if (m_age >= SIDE_GREEN) nx = SIDE_Y;
            SIDE_Y:    if (m_age >= YELLOW) nx = ALL_RED_B;
            ALL_RED_B: if (m_age >= ALL_RED) begin
                if (flash_mode) nx = FLASH; else nx = MAIN_G;
            end
            FLASH:     if (!flash_mode) nx = ALL_RED_B;
            default:   nx = ALL_RED_B;
        endcase
        es = (nx == SIDE_G) && (m_ph != SIDE_G);
        m_ack = es && m_pend;
        if (es) m_served = m_pend;
        m_pend = ped_req || (m_pend && !es);
        m_age  = (nx == m_ph) ? m_age + 1 : 1;
        m_ph   = nx;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_ph = ALL_RED_B; m_age = 1; m_pend = 0; m_served = 0; m_ack = 0;
    endtask

    task automatic do_reset();
        rst_an = 1'b0; en = 1'b1; flash_mode = 1'b0; side_sensor = 1'b0; ped_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_an = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({main_rgy, side_rgy, walk, ped_ack} !== 8'b100_100_0_0) begin
            n_fail++; $display("FAIL reset_outputs got=%b want=%b", {main_rgy, side_rgy, walk, ped_ack}, 8'b100_100_0_0);
        end
        n_checks++;
        if (phase !== 3'd5) begin
            n_fail++; $display("FAIL reset_phase got=%0d want=5", phase);
        end
        step();
        n_checks++;
        if (phase !== 3'd5) begin
            n_fail++; $display("FAIL reset_allred2 got=%0d want=5", phase);
        end
        step();
        n_checks++;
        if (phase !== 3'd0) begin
            n_fail++; $display("FAIL reset_to_main got=%0d want=0", phase);
        end
        for (int i = 0; i < 200; i++) begin
            step();
            n_checks++;
            if ({main_rgy, side_rgy} !== 6'b001_100 || dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL main_hold cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_side_demand();
        int q[$];
        int sp[$], sn[$];
        int ep[7];
        int en_[7];
        ep  = '{0, 1, 2, 3, 4, 5, 0};
        en_ = '{20, 3, 2, 10, 3, 2, 1};
        do_reset();
        step(); step();
        q.push_back(int'(phase));
        for (int i = 2; i <= 41; i++) begin
            if (i == 6) side_sensor = 1'b1;
            step();
            q.push_back(int'(phase));
            n_checks++;
            if (walk !== 1'b0 || dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL side_cycle i=%0d got=%b want=%b", i, dut_vec, model_vec());
            end
        end
        side_sensor = 1'b0;
        foreach (q[k]) begin
            if (sp.size() != 0 && sp[sp.size()-1] == q[k]) sn[sn.size()-1]++;
            else begin sp.push_back(q[k]); sn.push_back(1); end
        end
        n_checks++;
        if (sp.size() != 7) begin
            n_fail++; $display("FAIL side_segments got=%0d want=7", sp.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if (sp[k] != ep[k] || sn[k] != en_[k]) begin
                    n_fail++; $display("FAIL side_seg%0d got=%0d/%0d want=%0d/%0d", k, sp[k], sn[k], ep[k], en_[k]);
                end
            end
        end
    endtask

    task automatic test_ped();
        int acks, walks, prev;
        acks = 0; walks = 0;
        do_reset();
        step(); step();
        for (int i = 2; i <= 25; i++) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n_checks++;
        if (phase !== 3'd1) begin
            n_fail++; $display("FAIL ped_to_yellow got=%0d want=1", phase);
        end
        prev = int'(phase);
        for (int i = 0; i < 30; i++) begin
            step();
            if (ped_ack === 1'b1) acks++;
            if (walk === 1'b1) walks++;
            n_checks++;
            if (dut_vec !== model_vec() || (ped_ack === 1'b1 && !(phase == 3'd3 && prev != 3)))
            begin
                n_fail++; $display("FAIL ped_cycle i=%0d got=%b want=%b", i, dut_vec, model_vec());
            end
            prev = int'(phase);
        end
        n_checks++;
        if (acks != 1) begin n_fail++; $display("FAIL ped_ack_count got=%0d want=1", acks); end
        n_checks++;
        if (walks != SIDE_GREEN) begin n_fail++; $display("FAIL walk_count got=%0d want=10", walks); end
    endtask

    task automatic test_flash();
        int ny, nar, guard;
        logic [2:0] wm, ws;
        ny = 0; nar = 0; guard = 0;
        do_reset();
        step(); step(); step(); step();
        flash_mode = 1'b1; side_sensor = 1'b1;
        while (phase !== 3'd6 && guard < 60) begin
            step();
            guard++;
            if (phase == 3'd1) ny++;
            if (phase == 3'd2) nar++;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL flash_entry cyc=%0d got=%b want=%b", guard, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (phase !== 3'd6 || ny != YELLOW || nar != ALL_RED) begin
            n_fail++; $display("FAIL flash_reach got=%0d y=%0d ar=%0d want=6 y=3 ar=2", phase, ny, nar);
        end
        side_sensor = 1'b0;
        for (int k = 0; k < 16; k++) begin
            wm = (((k / 4) % 2) == 0) ? 3'b010 : 3'b000;
            ws = (((k / 4) % 2) == 0) ? 3'b100 : 3'b000;
            n_checks++;
            if (main_rgy !== wm || side_rgy !== ws || dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL flash_toggle k=%0d got=%b/%b want=%b/%b", k, main_rgy, side_rgy, wm, ws);
            end
            step();
        end
        flash_mode = 1'b0;
        step();
        n_checks++;
        if (phase !== 3'd5) begin n_fail++; $display("FAIL flash_exit1 got=%0d want=5", phase); end
        step();
        n_checks++;
        if (phase !== 3'd5) begin n_fail++; $display("FAIL flash_exit2 got=%0d want=5", phase); end
        step();
        n_checks++;
        if (phase !== 3'd0 || main_rgy !== 3'b001 || dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL flash_to_main got=%b want=%b", dut_vec, model_vec());
        end
    endtask

    task automatic test_enable();
        int sg, guard, more;
        logic [10:0] snap;
        sg = 0; guard = 0; more = 0;
        do_reset();
        side_sensor = 1'b1;
        while (sg < 4 && guard < 100) begin
            step();
            guard++;
            if (phase == 3'd3) sg++;
        end
        side_sensor = 1'b0;
        en = 1'b0;
        snap = dut_vec;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if (dut_vec !== snap || dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL freeze i=%0d got=%b want=%b", i, dut_vec, snap);
            end
        end
        en = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
            if (phase == 3'd3) more++;
        end while (phase == 3'd3 && guard < 20);
        n_checks++;
        if (more != 6 || dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL resume_len got=%0d want=6", more);
        end
    endtask

    task automatic test_async_reset();
        int sg, guard;
        sg = 0; guard = 0;
        do_reset();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        while (sg < 3 && guard < 100) begin
            step();
            guard++;
            if (phase == 3'd3) sg++;
        end
        n_checks++;
        if (walk !== 1'b1 || phase !== 3'd3) begin
            n_fail++; $display("FAIL pre_reset_walk got=%b/%0d want=1/3", walk, phase);
        end
        #2 rst_an = 1'b0;
        #1;
        n_checks++;
        if ({main_rgy, side_rgy, walk, ped_ack, phase} !== 11'b100_100_0_0_101) begin
            n_fail++; $display("FAIL async_reset got=%b want=%b", {main_rgy, side_rgy, walk, ped_ack, phase}, 11'b100_100_0_0_101);
        end
        @(negedge clk);
        rst_an = 1'b1;
        model_reset();
        step();
        n_checks++;
        if (phase !== 3'd5) begin n_fail++; $display("FAIL restart_allred got=%0d want=5", phase); end
        step();
        n_checks++;
        if (phase !== 3'd0 || {main_rgy, side_rgy} !== 6'b001_100) begin
            n_fail++; $display("FAIL restart_main got=%b want=%b", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom % 10) != 0;
            ped_req = ($urandom % 25) == 0;
            if (($urandom % 6) == 0) side_sensor = ~side_sensor;
            if (($urandom % 300) == 0) flash_mode = ~flash_mode;
            step();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
            end
            n_checks++;
            if (phase != 3'd6 && main_rgy != 3'b100 && side_rgy != 3'b100) begin
                n_fail++; $display("FAIL conflict cyc=%0d main=%b side=%b want one red", i, main_rgy, side_rgy);
            end
        end
        ped_req = 1'b0; flash_mode = 1'b0; side_sensor = 1'b0; en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_side_demand();
        test_ped();
        test_flash();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
